axi_dbus_arbiter: RTL
=====================

# axi_dbus_arbiter

Two-master to one-slave AXI4 arbiter that shares the MiniRv32 64-bit data bus (the Top `dBus_*` port) between two requesters, e.g. the core data port and a DMA engine. Read and write paths arbitrate independently. Each path uses round-robin grant and allows one outstanding transaction at a time. Addresses, IDs, burst attributes and data pass through unmodified. Responses are routed to the current owner, so no ID remapping is required.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- ID_W, 16, transaction ID width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m{0,1}_arvalid in 1 / m{0,1}_arready out 1 / m{0,1}_araddr in ADDR_W / m{0,1}_arid in ID_W / m{0,1}_arlen in 8 / m{0,1}_arsize in 3 / m{0,1}_arburst in 2  master read-address channels
- m{0,1}_rvalid out 1 / m{0,1}_rready in 1 / m{0,1}_rdata out DATA_W / m{0,1}_rid out ID_W / m{0,1}_rresp out 2 / m{0,1}_rlast out 1  master read-data channels
- m{0,1}_awvalid/awready/awaddr/awid/awlen/awsize/awburst  same directions and widths as the AR group  master write-address channels
- m{0,1}_wvalid in 1 / m{0,1}_wready out 1 / m{0,1}_wdata in DATA_W / m{0,1}_wstrb in DATA_W/8 / m{0,1}_wlast in 1  master write-data channels
- m{0,1}_bvalid out 1 / m{0,1}_bready in 1 / m{0,1}_bid out ID_W / m{0,1}_bresp out 2  master write-response channels
- s_ar*, s_r*, s_aw*, s_w*, s_b*  same signal sets with directions inverted  slave-side AXI4 port to `dBus_*`
- rd_busy out 1  read path not in R_IDLE
- wr_busy out 1  write path not in W_IDLE
- rd_owner out 1  index of the current read grant
- wr_owner out 1  index of the current write grant

## Operation
- Read FSM has three states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any m_arvalid is high, grant one master and go to R_ADDR. Priority goes to the master not granted last; rd_rr is a 1-bit pointer.
  - R_ADDR: s_ar* is muxed from the owner, and owner arready = s_arready. On an s_ar handshake, go to R_DATA.
  - R_DATA: s_r* goes to the owner, and s_rready = owner rready. On a handshake with s_rlast, go to R_IDLE and set rd_rr = owner.
- Write FSM has three states: W_IDLE, W_ACT, W_RESP.
  - Grant is decided on m_awvalid only, with the same round-robin rule using wr_rr.
  - W_ACT: AW and W are forwarded concurrently from the owner. Flag aw_done is set on the AW handshake. Flag w_done is set on the W handshake with wlast. When both are set, or are being set this cycle, go to W_RESP.
  - W_RESP: B goes to the owner, and s_bready = owner bready. On the B handshake, go to W_IDLE and set wr_rr = owner.
  - W beats are forwarded while in W_ACT until w_done. Once w_done is set, wready stays 0.
- Masters without a grant see arready, awready, wready, rvalid and bvalid all at 0. Their payload outputs mirror the slave side but are don't-care.
- Outside their forwarding states, s_arvalid, s_awvalid, s_wvalid, s_rready and s_bready are 0. A stray slave response in an idle state is held off and never routed.
- Read and write paths are fully independent and may have different owners in the same cycle.
- A master may present W before AW. Its W stalls (wready=0) until it holds the write grant.

## Timing
- Reset values:
  - Both FSMs idle.
  - rd_rr = wr_rr = 1, so m0 wins the first contention.
  - aw_done = w_done = 0.
  - rd_busy, wr_busy, rd_owner and wr_owner are all 0.
  - Every valid and ready output is 0.
- Grant latency:
  - m_arvalid or m_awvalid sampled high in idle at edge N gives state and owner registered at N.
  - s_arvalid or s_awvalid is high in cycle N+1. This is one bubble cycle.
- Within a grant, valid, ready and payload are combinational muxes with no added latency. Full-throughput bursts are supported (one beat per cycle).
- Turnaround:
  - Last handshake at edge N gives idle during cycle N+1.
  - The earliest next s_arvalid or s_awvalid is cycle N+2.
- Busy flags and owner outputs are registered and valid from the cycle after the grant edge.
- Simultaneous AW handshake and wlast handshake in the same cycle go directly to W_RESP.
- Reset mid-operation: the FSMs return to idle at the reset edge. Outputs are at reset values in the next cycle, and in-flight beats are dropped. The slave is reset with the same rst.
- Masters must hold valid and payload stable until ready, per AXI4. The arbiter relies on this because payloads are not registered.

## Test plan
- Single read, m0, araddr=0x8000_0040, arlen=3, arid=0x0005 -> s_arvalid rises 1 cycle after m0_arvalid with identical payload. Four beats reach m0 with rid=0x0005. m1_rvalid stays 0. rd_busy falls the cycle after rlast.
- Both masters assert arvalid simultaneously after reset, three times back-to-back (arlen=0) -> grant order is m0, m1, m0. Each new s_arvalid appears 2 cycles after the previous rlast.
- m1 drives wvalid (wlast=1) 3 cycles before awvalid, awlen=0, awaddr=0x8000_1000 -> m1_wready stays 0 until the grant. AW and W then complete, and B with bid=m1 awid and bresp=0 reaches m1 only.
- Concurrent m0 read (arlen=7) and m1 write (awlen=1) -> both complete with no interleaving stalls. rd_owner=0 and wr_owner=1 while both are busy.
- Read burst arlen=3 with m0_rready low for 2 cycles on beat 2 -> s_rready is low for the same cycles. No beat is lost or duplicated, and rdata is observed in order.
- rst asserted during beat 2 of an arlen=7 burst -> next cycle both FSMs are idle, all ready/valid outputs are 0, and a subsequent simultaneous request grants m0.

Source files
------------

// File: rtl/axi_dbus_arbiter.sv
// axi_dbus_arbiter: two-master round-robin AXI4 arbiter sharing the dBus, independent read/write paths.
module axi_dbus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_arvalid, output logic m0_arready, input logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0] m0_arid, input logic [7:0] m0_arlen, input logic [2:0] m0_arsize, input logic [1:0] m0_arburst,
  output logic m0_rvalid, input logic m0_rready, output logic [DATA_W-1:0] m0_rdata,
  output logic [ID_W-1:0] m0_rid, output logic [1:0] m0_rresp, output logic m0_rlast,
  input  logic m0_awvalid, output logic m0_awready, input logic [ADDR_W-1:0] m0_awaddr,
  input  logic [ID_W-1:0] m0_awid, input logic [7:0] m0_awlen, input logic [2:0] m0_awsize, input logic [1:0] m0_awburst,
  input  logic m0_wvalid, output logic m0_wready, input logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb, input logic m0_wlast,
  output logic m0_bvalid, input logic m0_bready, output logic [ID_W-1:0] m0_bid, output logic [1:0] m0_bresp,
  input  logic m1_arvalid, output logic m1_arready, input logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0] m1_arid, input logic [7:0] m1_arlen, input logic [2:0] m1_arsize, input logic [1:0] m1_arburst,
  output logic m1_rvalid, input logic m1_rready, output logic [DATA_W-1:0] m1_rdata,
  output logic [ID_W-1:0] m1_rid, output logic [1:0] m1_rresp, output logic m1_rlast,
  input  logic m1_awvalid, output logic m1_awready, input logic [ADDR_W-1:0] m1_awaddr,
  input  logic [ID_W-1:0] m1_awid, input logic [7:0] m1_awlen, input logic [2:0] m1_awsize, input logic [1:0] m1_awburst,
  input  logic m1_wvalid, output logic m1_wready, input logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb, input logic m1_wlast,
  output logic m1_bvalid, input logic m1_bready, output logic [ID_W-1:0] m1_bid, output logic [1:0] m1_bresp,
  output logic s_arvalid, input logic s_arready, output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0] s_arid, output logic [7:0] s_arlen, output logic [2:0] s_arsize, output logic [1:0] s_arburst,
  input  logic s_rvalid, output logic s_rready, input logic [DATA_W-1:0] s_rdata,
  input  logic [ID_W-1:0] s_rid, input logic [1:0] s_rresp, input logic s_rlast,
  output logic s_awvalid, input logic s_awready, output logic [ADDR_W-1:0] s_awaddr,
  output logic [ID_W-1:0] s_awid, output logic [7:0] s_awlen, output logic [2:0] s_awsize, output logic [1:0] s_awburst,
  output logic s_wvalid, input logic s_wready, output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb, output logic s_wlast,
  input  logic s_bvalid, output logic s_bready, input logic [ID_W-1:0] s_bid, input logic [1:0] s_bresp,
  output logic rd_busy,
  output logic wr_busy,
  output logic rd_owner,
  output logic wr_owner
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rdState_e;
  typedef enum logic [1:0] {W_IDLE, W_ACT, W_RESP} wrState_e;
  rdState_e rdState, rdStateNxt;
  wrState_e wrState, wrStateNxt;
  logic rdOwner, rdOwnerNxt, rdRr, rdRrNxt, wrOwner, wrOwnerNxt, wrRr, wrRrNxt;
  logic awDone, awDoneNxt, wDone, wDoneNxt;
  logic rdAddr, rdData, awOpen, wOpen, wrResp, awHs, wLastHs;
  always_ff @(posedge clk)
    if (rst) begin
      rdState <= R_IDLE;
      wrState <= W_IDLE;
      rdOwner <= 1'b0;
      wrOwner <= 1'b0;
      rdRr <= 1'b1;
      wrRr <= 1'b1;
      awDone <= 1'b0;
      wDone <= 1'b0;
    end else begin
      rdState <= rdStateNxt;
      wrState <= wrStateNxt;
      rdOwner <= rdOwnerNxt;
      wrOwner <= wrOwnerNxt;
      rdRr <= rdRrNxt;
      wrRr <= wrRrNxt;
      awDone <= awDoneNxt;
      wDone <= wDoneNxt;
    end
  assign rdAddr = rdState == R_ADDR;
  assign rdData = rdState == R_DATA;
  assign awOpen = wrState == W_ACT && !awDone;
  assign wOpen = wrState == W_ACT && !wDone;
  assign wrResp = wrState == W_RESP;
  assign rd_busy = rdState != R_IDLE;
  assign wr_busy = wrState != W_IDLE;
  assign rd_owner = rdOwner;
  assign wr_owner = wrOwner;
  assign s_arvalid = rdAddr && (rdOwner ? m1_arvalid : m0_arvalid);
  assign s_araddr = rdOwner ? m1_araddr : m0_araddr;
  assign s_arid = rdOwner ? m1_arid : m0_arid;
  assign s_arlen = rdOwner ? m1_arlen : m0_arlen;
  assign s_arsize = rdOwner ? m1_arsize : m0_arsize;
  assign s_arburst = rdOwner ? m1_arburst : m0_arburst;
  assign m0_arready = rdAddr && !rdOwner && s_arready;
  assign m1_arready = rdAddr && rdOwner && s_arready;
  assign s_rready = rdData && (rdOwner ? m1_rready : m0_rready);
  assign m0_rvalid = rdData && !rdOwner && s_rvalid;
  assign m1_rvalid = rdData && rdOwner && s_rvalid;
  assign {m0_rdata, m0_rid, m0_rresp, m0_rlast} = {s_rdata, s_rid, s_rresp, s_rlast};
  assign {m1_rdata, m1_rid, m1_rresp, m1_rlast} = {s_rdata, s_rid, s_rresp, s_rlast};
  assign s_awvalid = awOpen && (wrOwner ? m1_awvalid : m0_awvalid);
  assign s_awaddr = wrOwner ? m1_awaddr : m0_awaddr;
  assign s_awid = wrOwner ? m1_awid : m0_awid;
  assign s_awlen = wrOwner ? m1_awlen : m0_awlen;
  assign s_awsize = wrOwner ? m1_awsize : m0_awsize;
  assign s_awburst = wrOwner ? m1_awburst : m0_awburst;
  assign m0_awready = awOpen && !wrOwner && s_awready;
  assign m1_awready = awOpen && wrOwner && s_awready;
  assign s_wvalid = wOpen && (wrOwner ? m1_wvalid : m0_wvalid);
  assign s_wdata = wrOwner ? m1_wdata : m0_wdata;
  assign s_wstrb = wrOwner ? m1_wstrb : m0_wstrb;
  assign s_wlast = wrOwner ? m1_wlast : m0_wlast;
  assign m0_wready = wOpen && !wrOwner && s_wready;
  assign m1_wready = wOpen && wrOwner && s_wready;
  assign s_bready = wrResp && (wrOwner ? m1_bready : m0_bready);
  assign m0_bvalid = wrResp && !wrOwner && s_bvalid;
  assign m1_bvalid = wrResp && wrOwner && s_bvalid;
  assign {m0_bid, m0_bresp} = {s_bid, s_bresp};
  assign {m1_bid, m1_bresp} = {s_bid, s_bresp};
  assign awHs = s_awvalid && s_awready;
  assign wLastHs = s_wvalid && s_wready && s_wlast;
  always_comb begin
    rdStateNxt = rdState;
    rdOwnerNxt = rdOwner;
    rdRrNxt = rdRr;
    if (rdState == R_IDLE && (m0_arvalid || m1_arvalid)) begin
      rdStateNxt = R_ADDR;
      rdOwnerNxt = (m0_arvalid && m1_arvalid) ? !rdRr : m1_arvalid;
    end
    if (rdAddr && s_arvalid && s_arready) rdStateNxt = R_DATA;
    if (rdData && s_rvalid && s_rready && s_rlast) begin
      rdStateNxt = R_IDLE;
      rdRrNxt = rdOwner;
    end
  end
  always_comb begin
    wrStateNxt = wrState;
    wrOwnerNxt = wrOwner;
    wrRrNxt = wrRr;
    awDoneNxt = awDone || awHs;
    wDoneNxt = wDone || wLastHs;
    if (wrState == W_IDLE && (m0_awvalid || m1_awvalid)) begin
      wrStateNxt = W_ACT;
      wrOwnerNxt = (m0_awvalid && m1_awvalid) ? !wrRr : m1_awvalid;
    end
    // flags clear as soon as both halves of the request have been accepted
    if (wrState == W_ACT && awDoneNxt && wDoneNxt) begin
      wrStateNxt = W_RESP;
      awDoneNxt = 1'b0;
      wDoneNxt = 1'b0;
    end
    if (wrResp && s_bvalid && s_bready) begin
      wrStateNxt = W_IDLE;
      wrRrNxt = wrOwner;
    end
  end
endmodule
